// File: rtl/hazard_unit_206_pkg.sv
// ---------------------------------------------------------------------------
// hazard_unit_206_pkg
// Shared pipeline definitions for the hazard unit and its helpers.
//   hz_state_e  : action taken by the hazard unit in a cycle, also the code
//                 reported on state_o one cycle later
//   REG_IDX_W   : width of a register-file index (Rs/Rt/WrReg fields)
//   ctrl_t      : bundle of the six pipeline control outputs
//   isLoadUse() : load-use hazard detection between ID and a load in EX
// ---------------------------------------------------------------------------
package hazard_unit_206_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_FLUSH      = 2'd2,
      ST_MEM_WAIT   = 2'd3
   } hz_state_e;

   typedef struct packed {
      logic stallPc;
      logic stallIfId;
      logic stallIdEx;
      logic flushIfId;
      logic bubbleIdEx;
      logic stallExMem;
   } ctrl_t;

   // A load in EX whose destination is read by the ID instruction must hold
   // ID for one cycle. Register $0 is hard-wired to zero, so a "write" to it
   // never creates a true dependence.
   function automatic logic isLoadUse(
      input logic [REG_IDX_W-1:0] rsId,
      input logic [REG_IDX_W-1:0] rtId,
      input logic                 useRsId,
      input logic                 useRtId,
      input logic [REG_IDX_W-1:0] wrRegEx,
      input logic                 regWrEx,
      input logic                 memToRegEx
   );
      logic rsHit;
      logic rtHit;
      rsHit = useRsId && (rsId == wrRegEx);
      rtHit = useRtId && (rtId == wrRegEx);
      return memToRegEx && regWrEx && (wrRegEx != '0) && (rsHit || rtHit);
   endfunction

endpackage

// File: rtl/sat_counter_206.sv
// ---------------------------------------------------------------------------
// sat_counter_206
// Event counter that counts up by one per cycle with inc=1 and sticks at its
// all-ones maximum instead of wrapping.
//   clk  : clock, counts on the rising edge
//   rst  : synchronous active-high reset, clears the count
//   inc  : count this cycle
//   q    : current count
// ---------------------------------------------------------------------------
module sat_counter_206 #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: hold at the all-ones value once reached so long runs of
   // stalls or flushes read as "at least this many" rather than wrapping.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign q = count_q;

endmodule

// File: rtl/hazard_unit_206.sv
// ---------------------------------------------------------------------------
// hazard_unit_206
// Pipeline hazard controller for a 5-stage MIPS-style pipeline. Decides each
// cycle between freezing for a slow data memory, flushing after a redirect
// in EX, stalling ID for a load-use dependence, or running normally. The
// control outputs are combinational from the current inputs; the action is
// also registered onto state_o and counted.
//   clk, rst                 : clock and synchronous active-high reset
//   Rs_ID, Rt_ID             : source register fields of the ID instruction
//   UseRs_ID, UseRt_ID       : ID instruction actually reads Rs / Rt
//   WrReg_Ex, RegWr_Ex       : destination and write enable of the EX instr
//   MemToReg_Ex              : EX instruction is a load
//   Redirect_Ex              : taken branch / jump resolved in EX
//   mem_busy                 : MEM-stage data access not yet complete
//   stall_PC .. stall_EX_MEM : pipeline register hold / flush / bubble
//   state_o                  : action taken in the previous cycle
//   stall_cnt, flush_cnt     : saturating counts of stall / flush cycles
// ---------------------------------------------------------------------------
module hazard_unit_206
   import hazard_unit_206_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] Rs_ID,
   input  logic [REG_IDX_W-1:0] Rt_ID,
   input  logic                 UseRs_ID,
   input  logic                 UseRt_ID,
   input  logic [REG_IDX_W-1:0] WrReg_Ex,
   input  logic                 RegWr_Ex,
   input  logic                 MemToReg_Ex,
   input  logic                 Redirect_Ex,
   input  logic                 mem_busy,
   output logic                 stall_PC,
   output logic                 stall_IF_ID,
   output logic                 stall_ID_EX,
   output logic                 flush_IF_ID,
   output logic                 bubble_ID_EX,
   output logic                 stall_EX_MEM,
   output logic [1:0]           state_o,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   logic      loadUse;
   hz_state_e action_d;
   hz_state_e state_q;
   ctrl_t     ctrl;

   assign loadUse = isLoadUse(Rs_ID, Rt_ID, UseRs_ID, UseRt_ID,
                              WrReg_Ex, RegWr_Ex, MemToReg_Ex);

   // Pick this cycle's action by fixed priority. A memory freeze wins over
   // everything because no stage may advance; a redirect held through the
   // freeze simply wins once mem_busy drops, since EX was frozen with it and
   // still presents it. Reset forces RUN so every control output reads 0.
   always_comb begin
      action_d = ST_RUN;
      if (rst) begin
         action_d = ST_RUN;
      end else if (mem_busy) begin
         action_d = ST_MEM_WAIT;
      end else if (Redirect_Ex) begin
         action_d = ST_FLUSH;
      end else if (loadUse) begin
         action_d = ST_LOAD_STALL;
      end
   end

   // Decode the action into the pipeline controls. A load-use stall holds PC
   // and IF/ID while inserting a bubble into ID/EX; the load itself moves on,
   // so ID/EX and EX/MEM are not held.
   always_comb begin
      ctrl = '0;
      unique case (action_d)
         ST_MEM_WAIT: begin
            ctrl.stallPc    = 1'b1;
            ctrl.stallIfId  = 1'b1;
            ctrl.stallIdEx  = 1'b1;
            ctrl.stallExMem = 1'b1;
         end
         ST_FLUSH: begin
            ctrl.flushIfId  = 1'b1;
            ctrl.bubbleIdEx = 1'b1;
         end
         ST_LOAD_STALL: begin
            ctrl.stallPc    = 1'b1;
            ctrl.stallIfId  = 1'b1;
            ctrl.bubbleIdEx = 1'b1;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

   assign stall_PC     = ctrl.stallPc;
   assign stall_IF_ID  = ctrl.stallIfId;
   assign stall_ID_EX  = ctrl.stallIdEx;
   assign flush_IF_ID  = ctrl.flushIfId;
   assign bubble_ID_EX = ctrl.bubbleIdEx;
   assign stall_EX_MEM = ctrl.stallExMem;

   // Record the action taken this cycle so state_o reports it one cycle
   // later; useful for tracing which hazard held the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= action_d;
      end
   end

   assign state_o = state_q;

   // Event counters: cycles with PC held, and cycles with IF/ID flushed.
   sat_counter_206 #(
      .CNT_W (CNT_W)
   ) u_stallCounter (
      .clk (clk),
      .rst (rst),
      .inc (ctrl.stallPc),
      .q   (stall_cnt)
   );

   sat_counter_206 #(
      .CNT_W (CNT_W)
   ) u_flushCounter (
      .clk (clk),
      .rst (rst),
      .inc (ctrl.flushIfId),
      .q   (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_unit_206.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit_206
// Self-checking bench for hazard_unit_206: directed hazard scenarios, a long
// saturation run, then randomized traffic, all checked against a small
// behavioural model of the hazard rules.
// ---------------------------------------------------------------------------
module tb_hazard_unit_206;

   logic       clk;
   logic       rst;
   logic [4:0] Rs_ID;
   logic [4:0] Rt_ID;
   logic       UseRs_ID;
   logic       UseRt_ID;
   logic [4:0] WrReg_Ex;
   logic       RegWr_Ex;
   logic       MemToReg_Ex;
   logic       Redirect_Ex;
   logic       mem_busy;
   logic       stall_PC;
   logic       stall_IF_ID;
   logic       stall_ID_EX;
   logic       flush_IF_ID;
   logic       bubble_ID_EX;
   logic       stall_EX_MEM;
   logic [1:0] state_o;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int errors;
   int checks;

   // Reference model state
   int expState;
   int expStall;
   int expFlush;

   localparam int CNT_MAX = 65535;

   hazard_unit_206 #(
      .CNT_W (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .Rs_ID        (Rs_ID),
      .Rt_ID        (Rt_ID),
      .UseRs_ID     (UseRs_ID),
      .UseRt_ID     (UseRt_ID),
      .WrReg_Ex     (WrReg_Ex),
      .RegWr_Ex     (RegWr_Ex),
      .MemToReg_Ex  (MemToReg_Ex),
      .Redirect_Ex  (Redirect_Ex),
      .mem_busy     (mem_busy),
      .stall_PC     (stall_PC),
      .stall_IF_ID  (stall_IF_ID),
      .stall_ID_EX  (stall_ID_EX),
      .flush_IF_ID  (flush_IF_ID),
      .bubble_ID_EX (bubble_ID_EX),
      .stall_EX_MEM (stall_EX_MEM),
      .state_o      (state_o),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Hazard rules in plain form: returns the action code
   // (0 run, 1 load stall, 2 flush, 3 memory wait).
   function automatic int modelAction(input logic r, input logic mb,
                                      input logic redir, input logic lu);
      if (r)     return 0;
      if (mb)    return 3;
      if (redir) return 2;
      if (lu)    return 1;
      return 0;
   endfunction

   // Controls per action as {stall_PC, stall_IF_ID, stall_ID_EX,
   // flush_IF_ID, bubble_ID_EX, stall_EX_MEM}.
   function automatic logic [5:0] modelCtrl(input int act);
      case (act)
         3:       return 6'b111001;
         2:       return 6'b000110;
         1:       return 6'b110010;
         default: return 6'b000000;
      endcase
   endfunction

   function automatic logic modelLoadUse();
      logic hitRs;
      logic hitRt;
      hitRs = UseRs_ID && (Rs_ID == WrReg_Ex);
      hitRt = UseRt_ID && (Rt_ID == WrReg_Ex);
      return MemToReg_Ex && RegWr_Ex && (WrReg_Ex != 5'd0) && (hitRs || hitRt);
   endfunction

   // Drive one cycle of inputs, check the combinational controls mid-cycle,
   // then advance the model across the clock edge and check registered state.
   task automatic applyStimulus(input logic r, input logic [4:0] rs,
                                input logic [4:0] rt, input logic urs,
                                input logic urt, input logic [4:0] wr,
                                input logic rw, input logic m2r,
                                input logic redir, input logic mb,
                                input string tag);
      int act;
      logic [5:0] expCtrl;
      rst = r; Rs_ID = rs; Rt_ID = rt; UseRs_ID = urs; UseRt_ID = urt;
      WrReg_Ex = wr; RegWr_Ex = rw; MemToReg_Ex = m2r;
      Redirect_Ex = redir; mem_busy = mb;
      #3;
      act = modelAction(r, mb, redir, modelLoadUse());
      expCtrl = modelCtrl(act);
      checkOutput({tag, "_ctrl"},
                  {26'd0, stall_PC, stall_IF_ID, stall_ID_EX, flush_IF_ID,
                   bubble_ID_EX, stall_EX_MEM},
                  {26'd0, expCtrl});
      @(posedge clk);
      if (r) begin
         expState = 0; expStall = 0; expFlush = 0;
      end else begin
         expState = act;
         if (expCtrl[5] && expStall < CNT_MAX) expStall++;
         if (expCtrl[2] && expFlush < CNT_MAX) expFlush++;
      end
      #1;
      checkOutput({tag, "_state"}, {30'd0, state_o}, expState);
      checkOutput({tag, "_stallCnt"}, {16'd0, stall_cnt}, expStall);
      checkOutput({tag, "_flushCnt"}, {16'd0, flush_cnt}, expFlush);
   endtask

   initial begin
      int savedStall;
      int savedFlush;
      errors = 0; checks = 0;
      expState = 0; expStall = 0; expFlush = 0;
      rst = 1'b1; Rs_ID = '0; Rt_ID = '0; UseRs_ID = 0; UseRt_ID = 0;
      WrReg_Ex = '0; RegWr_Ex = 0; MemToReg_Ex = 0; Redirect_Ex = 0;
      mem_busy = 0;
      @(posedge clk); #1;

      // Reset state
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");

      // lw $5 in EX, ID reads Rs=5: load-use stall
      applyStimulus(0, 5, 2, 1, 1, 5, 1, 1, 0, 0, "loadUseRs");
      checkOutput("loadUseStateCode", {30'd0, state_o}, 1);
      // Match on Rt only
      applyStimulus(0, 1, 7, 1, 1, 7, 1, 1, 0, 0, "loadUseRt");
      // Matching Rt not used: no hazard
      applyStimulus(0, 1, 7, 1, 0, 7, 1, 1, 0, 0, "rtUnused");
      // Load writing $0, ID reads $0: nothing
      applyStimulus(0, 0, 0, 1, 1, 0, 1, 1, 0, 0, "zeroReg");
      // Non-load ALU op writing the same register: forwarding handles it
      applyStimulus(0, 5, 5, 1, 1, 5, 1, 0, 0, 0, "aluNoStall");

      // Redirect together with load-use: flush wins
      savedFlush = expFlush;
      applyStimulus(0, 5, 2, 1, 1, 5, 1, 1, 1, 0, "redirLoadUse");
      checkOutput("redirFlushInc", flush_cnt, savedFlush + 1);

      // mem_busy for 3 cycles with redirect held, flush on the 4th
      savedStall = expStall;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 3, 4, 1, 1, 3, 1, 1, 1, 1, "memWaitRedir");
      end
      checkOutput("freezeStallInc", stall_cnt, savedStall + 3);
      applyStimulus(0, 3, 4, 1, 1, 3, 1, 1, 1, 0, "redirAfterFreeze");
      checkOutput("freezeThenFlush", {30'd0, state_o}, 2);

      // Reset pulsed mid-freeze and mid-flush
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "preRstFreeze");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rstInFreeze");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "rstInFlush");
      // Live re-evaluation right after reset drops
      applyStimulus(0, 9, 0, 1, 0, 9, 1, 1, 0, 0, "postRstLoadUse");

      // Saturation: drive a long freeze without per-cycle checks
      rst = 0; Redirect_Ex = 0; MemToReg_Ex = 0; mem_busy = 1;
      for (int i = 0; i < CNT_MAX + 3; i++) begin
         @(posedge clk);
         if (expStall < CNT_MAX) expStall++;
      end
      expState = 3;
      #1;
      checkOutput("stallSaturated", {16'd0, stall_cnt}, 32'h0000FFFF);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "stallStaysMax");
      checkOutput("stillFFFF", {16'd0, stall_cnt}, 32'h0000FFFF);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rstAfterSat");

      // Randomized traffic with small register indices to provoke hazards
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 24) == 0),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                       "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
